// File: rtl/seq_alu.sv
// seq_alu: registered ALU with single-cycle logic/arith/shift ops and an
// iterative unsigned multiply (shift-add) and restoring divide that stall
// the issuing stage through a valid/ready handshake.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       cmd,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             ovf
);

    localparam logic [3:0] CMD_ADD  = 4'b0000;
    localparam logic [3:0] CMD_SUB  = 4'b0010;
    localparam logic [3:0] CMD_AND  = 4'b0100;
    localparam logic [3:0] CMD_OR   = 4'b0101;
    localparam logic [3:0] CMD_NOR  = 4'b0110;
    localparam logic [3:0] CMD_XOR  = 4'b0111;
    localparam logic [3:0] CMD_SLL  = 4'b1000;
    localparam logic [3:0] CMD_SRA  = 4'b1001;
    localparam logic [3:0] CMD_SRL  = 4'b1010;
    localparam logic [3:0] CMD_MULU = 4'b1100;
    localparam logic [3:0] CMD_DIVU = 4'b1110;

    localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q;
    logic [SHW-1:0]     cnt_q;
    logic               is_div_q;
    // acc: product high word / partial remainder
    // lo : multiplier being consumed / dividend shifting out, quotient in
    // opb: multiplicand / divisor
    logic [WIDTH-1:0]   acc_q, lo_q, opb_q;
    logic               out_valid_q, zero_q, ovf_q;
    logic [WIDTH-1:0]   result_q, result_hi_q;

    logic [WIDTH-1:0]        sum, diff, sc_res, sc_hi;
    logic                    sc_ovf, start_multi;
    logic [SHW-1:0]          shamt;
    logic signed [WIDTH-1:0] in1_s;
    logic [WIDTH:0]          mul_sum, div_sh, div_diff;
    logic [WIDTH-1:0]        acc_d, lo_d;

    assign shamt    = in2[SHW-1:0];
    assign in1_s    = in1;
    assign in_ready = (state_q == IDLE);

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;

    // Iterative ops leave the single-cycle path; divide by zero does not.
    assign start_multi = (cmd == CMD_MULU) || ((cmd == CMD_DIVU) && (in2 != '0));

    // Single-cycle result, high word and overflow for the command on the inputs.
    always_comb begin
        sum    = in1 + in2;
        diff   = in1 - in2;
        sc_res = '0;
        sc_hi  = '0;
        sc_ovf = 1'b0;
        case (cmd)
            CMD_ADD: begin
                sc_res = sum;
                sc_ovf = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
            end
            CMD_SUB: begin
                sc_res = diff;
                sc_ovf = (in1[WIDTH-1] != in2[WIDTH-1]) && (diff[WIDTH-1] != in1[WIDTH-1]);
            end
            CMD_AND: sc_res = in1 & in2;
            CMD_OR:  sc_res = in1 | in2;
            CMD_NOR: sc_res = ~(in1 | in2);
            CMD_XOR: sc_res = in1 ^ in2;
            CMD_SLL: sc_res = in1 << shamt;
            CMD_SRL: sc_res = in1 >> shamt;
            CMD_SRA: sc_res = in1_s >>> shamt;
            CMD_DIVU: begin
                // Only reaches here with a zero divisor.
                sc_res = '1;
                sc_hi  = in1;
            end
            default: begin
                sc_res = '0;
                sc_hi  = '0;
            end
        endcase
    end

    // One shift-add (multiply) or shift-subtract (restoring divide) step.
    always_comb begin
        mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        div_sh   = {acc_q, lo_q[WIDTH-1]};
        div_diff = div_sh - {1'b0, opb_q};
        if (is_div_q) begin
            // Partial remainder stays below the divisor, so a negative
            // difference always shows up in the top bit.
            acc_d = div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
            lo_d  = {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
            acc_d = mul_sum[WIDTH:1];
            lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    // Control FSM, iteration state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            is_div_q    <= 1'b0;
            acc_q       <= '0;
            lo_q        <= '0;
            opb_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (start_multi) begin
                            acc_q    <= '0;
                            lo_q     <= in1;
                            opb_q    <= in2;
                            is_div_q <= (cmd == CMD_DIVU);
                            cnt_q    <= '0;
                            state_q  <= BUSY;
                        end else begin
                            result_q    <= sc_res;
                            result_hi_q <= sc_hi;
                            zero_q      <= (sc_res == '0);
                            ovf_q       <= sc_ovf;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    acc_q <= acc_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_STEP) begin
                        // Final step: low word/quotient in lo, high word/remainder in acc.
                        result_q    <= lo_d;
                        result_hi_q <= acc_d;
                        zero_q      <= (lo_d == '0);
                        ovf_q       <= 1'b0;
                        out_valid_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed vectors with hand-computed expectations for seq_alu.
module tb_seq_alu;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    cmd;
    logic [W-1:0]  in1, in2;
    logic          out_valid;
    logic [W-1:0]  result, result_hi;
    logic          zero, ovf;

    int nvec = 0;
    int nerr = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cmd       (cmd),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .result    (result),
        .result_hi (result_hi),
        .zero      (zero),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Present one command for a single edge; returns 1ns after the accepting edge.
    task automatic issue(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        cmd      = c;
        in1      = a;
        in2      = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count cycles until out_valid, bounded.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 0; i < W + 8; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int busy_bad;
        rst      = 1'b0;
        in_valid = 1'b0;
        cmd      = 4'b0000;
        in1      = '0;
        in2      = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready",  64'(in_ready),  64'd1);
        check("rst_valid",  64'(out_valid), 64'd0);
        check("rst_result", 64'(result),    64'd0);
        check("rst_hi",     64'(result_hi), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // ADD with signed overflow
        issue(4'b0000, 32'h7FFF_FFFF, 32'h1);
        check("add_valid", 64'(out_valid), 64'd1);
        check("add_res",   64'(result),    64'h8000_0000);
        check("add_ovf",   64'(ovf),       64'd1);
        check("add_zero",  64'(zero),      64'd0);
        @(posedge clk);
        #1;
        check("add_pulse", 64'(out_valid), 64'd0);

        // SUB to zero
        issue(4'b0010, 32'h1234_5678, 32'h1234_5678);
        check("sub_res",  64'(result), 64'd0);
        check("sub_zero", 64'(zero),   64'd1);
        check("sub_ovf",  64'(ovf),    64'd0);

        // SUB overflow: 0x80000000 - 1
        issue(4'b0010, 32'h8000_0000, 32'h1);
        check("subovf_res", 64'(result), 64'h7FFF_FFFF);
        check("subovf_ovf", 64'(ovf),    64'd1);

        // Logic ops
        issue(4'b0100, 32'hF0F0_1234, 32'h0FF0_FFFF);
        check("and_res", 64'(result), 64'h00F0_1234);
        issue(4'b0101, 32'hF0F0_1234, 32'h0FF0_FFFF);
        check("or_res",  64'(result), 64'hFFF0_FFFF);
        issue(4'b0110, 32'hF0F0_1234, 32'h0FF0_FFFF);
        check("nor_res", 64'(result), 64'h000F_0000);
        issue(4'b0111, 32'hF0F0_1234, 32'h0FF0_FFFF);
        check("xor_res", 64'(result), 64'hFF00_EDCB);
        check("xor_hi",  64'(result_hi), 64'd0);

        // Shifts
        issue(4'b1000, 32'h0000_0001, 32'd31);
        check("sll_res", 64'(result), 64'h8000_0000);
        issue(4'b1010, 32'h8000_0000, 32'd4);
        check("srl_res", 64'(result), 64'h0800_0000);
        issue(4'b1001, 32'h8000_0000, 32'd36);
        check("sra_res", 64'(result), 64'hF800_0000);
        issue(4'b1001, 32'h4000_0000, 32'd2);
        check("sra_pos", 64'(result), 64'h1000_0000);

        // Undefined command
        issue(4'b0011, 32'hDEAD_BEEF, 32'h1);
        check("undef_res",  64'(result), 64'd0);
        check("undef_zero", 64'(zero),   64'd1);

        // MULU with an ADD held pending while busy
        issue(4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("mul_ready0", 64'(in_ready), 64'd0);
        in_valid = 1'b1;
        cmd      = 4'b0000;
        in1      = 32'd2;
        in2      = 32'd3;
        busy_bad = 0;
        for (int j = 1; j < W; j++) begin
            @(posedge clk);
            #1;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) busy_bad++;
        end
        check("mul_busy", 64'(busy_bad), 64'd0);
        @(posedge clk);
        #1;
        check("mul_valid", 64'(out_valid), 64'd1);
        check("mul_lo",    64'(result),    64'h0000_0001);
        check("mul_hi",    64'(result_hi), 64'hFFFF_FFFE);
        check("mul_ready", 64'(in_ready),  64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("held_valid", 64'(out_valid), 64'd1);
        check("held_res",   64'(result),    64'd5);
        check("held_hi",    64'(result_hi), 64'd0);

        // DIVU 100 / 7
        issue(4'b1110, 32'd100, 32'd7);
        wait_done(lat);
        check("div_lat", 64'(lat),       64'd32);
        check("div_q",   64'(result),    64'd14);
        check("div_r",   64'(result_hi), 64'd2);

        // MULU small operands
        issue(4'b1100, 32'h0001_0000, 32'h0003_0000);
        wait_done(lat);
        check("mul2_lat", 64'(lat),       64'd32);
        check("mul2_lo",  64'(result),    64'd0);
        check("mul2_hi",  64'(result_hi), 64'd3);
        check("mul2_zero", 64'(zero),     64'd1);

        // DIVU by zero
        issue(4'b1110, 32'd5, 32'd0);
        check("dz_valid", 64'(out_valid), 64'd1);
        check("dz_ready", 64'(in_ready),  64'd1);
        check("dz_q",     64'(result),    64'hFFFF_FFFF);
        check("dz_r",     64'(result_hi), 64'd5);

        // Reset in the middle of a MULU
        issue(4'b1100, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("mrst_ready",  64'(in_ready),  64'd1);
        check("mrst_valid",  64'(out_valid), 64'd0);
        check("mrst_result", 64'(result),    64'd0);
        check("mrst_hi",     64'(result_hi), 64'd0);
        check("mrst_flags",  64'({zero, ovf}), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        issue(4'b0000, 32'd3, 32'd4);
        check("post_valid", 64'(out_valid), 64'd1);
        check("post_res",   64'(result),    64'd7);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered ALU for the MIPS datapath. It keeps the existing command encodings for single-cycle operations and adds a multi-cycle unsigned multiply and divide. A valid/ready handshake lets the execute stage stall while the iterative unit is busy. Outputs are registered, so the block sits between EX and the EX/MEM pipeline register and supplies result, high word, and zero/overflow flags.

## Interface
- `WIDTH`, default 32: operand/result width. Power of two, ≥ 8.
- `SHW`, default $clog2(WIDTH): shift-amount width. Derived; do not override.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `in_valid`  in  1  command and operands present.
- `in_ready`  out  1  block can accept a command this cycle.
- `cmd`  in  4  operation code.
- `in1`  in  WIDTH  operand A.
- `in2`  in  WIDTH  operand B, or shift amount in its low SHW bits.
- `out_valid`  out  1  one-cycle pulse: outputs below are new.
- `result`  out  WIDTH  main result (MUL low word, DIVU quotient).
- `result_hi`  out  WIDTH  MUL high word, DIVU remainder; 0 for other ops.
- `zero`  out  1  result == 0.
- `ovf`  out  1  signed overflow for ADD/SUB; 0 otherwise.

## Operation
- A command is accepted on a rising edge where `in_valid && in_ready`. Inputs at other times are ignored, including while busy.
- Single-cycle commands (result into `result`):
  - 0000 ADD: in1+in2.
  - 0010 SUB: in1−in2.
  - 0100 AND.
  - 0101 OR.
  - 0110 NOR.
  - 0111 XOR.
  - 1000 SLL: in1<<in2[SHW-1:0].
  - 1010 SRL: logical right shift.
  - 1001 SRA: arithmetic right shift; vacated bits are copies of in1[WIDTH-1].
- Shift amounts use only `in2[SHW-1:0]`. Upper bits are ignored.
- Multi-cycle commands:
  - 1100 MULU: unsigned WIDTH×WIDTH, 2·WIDTH-bit product. `{result_hi,result}` = product.
  - 1110 DIVU: unsigned restoring division. `result` = quotient, `result_hi` = remainder.
- Divide by zero (DIVU with in2==0) completes as a single-cycle op: `result` = all ones, `result_hi` = in1.
- Undefined cmd completes as a single-cycle op with `result` = 0, `result_hi` = 0, `ovf` = 0.
- `ovf` on ADD: operands have the same sign and the result sign differs.
- `ovf` on SUB: operands have different signs and the result sign differs from in1.
- Wrap-around is modulo 2^WIDTH. No saturation.
- FSM states:
  - IDLE: `in_ready`=1. Accepting a single-cycle cmd stays in IDLE. Accepting MULU, or DIVU with in2≠0, loads operands, clears the accumulator and the iteration counter, then moves to BUSY.
  - BUSY: `in_ready`=0. One shift-add (MUL) or one shift-subtract (DIV) step per cycle. The counter runs 0..WIDTH−1. On the step where the counter is WIDTH−1, final values are written to the output registers and the FSM returns to IDLE.
- Output registers hold their value until the next completion.
- `zero` and `ovf` are meaningful only in the `out_valid` cycle. They stay held afterwards.
- Reset (`rst`=0, any time, including mid-BUSY) immediately forces:
  - state IDLE, counter 0;
  - `in_ready`=1, `out_valid`=0;
  - `result`=0, `result_hi`=0, `zero`=0, `ovf`=0.
  - The partial operation is discarded.

## Timing
- Single-cycle op accepted at edge k: `out_valid`=1 and outputs updated in the cycle after edge k. `in_ready` stays 1, so throughput is 1 op/cycle.
- MULU/DIVU accepted at edge k:
  - `in_ready`=0 from edge k to edge k+WIDTH.
  - Outputs update and `out_valid`=1 after edge k+WIDTH. Latency is WIDTH cycles.
  - `in_ready` is 1 again in that same `out_valid` cycle, so a new command can be accepted there (back-to-back, no bubble).
- `out_valid` is high for exactly one cycle per accepted command. There is no output backpressure.
- Consecutive completions from back-to-back accepts give consecutive `out_valid` pulses.

## Test plan
- ADD overflow, WIDTH=32: in1=0x7FFFFFFF, in2=1, cmd=0000 → next cycle `result`=0x80000000, `ovf`=1, `zero`=0, `out_valid` pulse.
- SUB to zero: in1=in2=0x12345678, cmd=0010 → `result`=0, `zero`=1, `ovf`=0.
- SRA with upper-bit masking: in1=0x80000000, in2=36, cmd=1001 → `result`=0xF8000000 (shift by 4).
- MULU: in1=in2=0xFFFFFFFF → `in_ready` low for 32 cycles; at 32-cycle latency `result`=0x00000001, `result_hi`=0xFFFFFFFE. An `in_valid` ADD held high while busy is ignored until `in_ready` returns, then accepted in the `out_valid` cycle; its result follows one cycle later.
- DIVU: 100/7 → `result`=14, `result_hi`=2 at 32-cycle latency. 5/0 → after 1 cycle `result`=0xFFFFFFFF, `result_hi`=5, `in_ready` never drops.
- Reset mid-MULU at busy cycle 10 → all outputs 0 and `in_ready`=1 immediately. After release, a new ADD 3+4 → `result`=7 one cycle after accept.
